// File: rtl/benes_cfg_sequencer_pkg.sv
// Shared definitions for the Benes switch-configuration sequencer and the
// Benes network modules that consume its select outputs.
package benes_cfg_sequencer_pkg;

  // Network geometry: 32-port Benes built from 2x2 switches.
  localparam int SWITCH_NUM = 16;
  localparam int STAGE_NUM  = 9;

  // Configuration table and hold-length sizing.
  localparam int CFG_DEPTH  = 16;
  localparam int LEN_W      = 8;
  localparam int CFG_AW     = $clog2(CFG_DEPTH);
  localparam int CFG_BITS   = SWITCH_NUM * STAGE_NUM;

  // One network's complete switch setting, indexed [switch][stage].
  typedef logic [SWITCH_NUM-1:0][0:STAGE_NUM-1] net_cfg_t;

  // Sequencer control state.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Table bank selector on the write port.
  typedef enum logic {
    SEL_R2M = 1'b0,
    SEL_M2R = 1'b1
  } bank_sel_e;

endpackage

// File: rtl/benes_cfg_table.sv
// Two-bank configuration table (R2M module-select, M2R slot-select).
// One synchronous write port, one combinational read port that returns both
// banks for the same entry. Reads see the contents before a same-cycle write.
module benes_cfg_table #(
  parameter int SWITCH_NUM = benes_cfg_sequencer_pkg::SWITCH_NUM,
  parameter int STAGE_NUM  = benes_cfg_sequencer_pkg::STAGE_NUM,
  parameter int CFG_DEPTH  = benes_cfg_sequencer_pkg::CFG_DEPTH
) (
  input  logic                                  clk,
  input  logic                                  wr_en,
  input  logic                                  wr_sel,
  input  logic [$clog2(CFG_DEPTH)-1:0]          wr_addr,
  input  logic [STAGE_NUM*SWITCH_NUM-1:0]       wr_data,
  input  logic [$clog2(CFG_DEPTH)-1:0]          rd_addr,
  output logic [SWITCH_NUM-1:0][0:STAGE_NUM-1]  rd_r2m,
  output logic [SWITCH_NUM-1:0][0:STAGE_NUM-1]  rd_m2r
);
  import benes_cfg_sequencer_pkg::*;

  localparam int ROW_W = STAGE_NUM * SWITCH_NUM;

  // Entries are kept in the flattened write layout; transposition happens
  // on the read side so the write path stays a plain RAM.
  logic [ROW_W-1:0] r2m_mem [CFG_DEPTH];
  logic [ROW_W-1:0] m2r_mem [CFG_DEPTH];

  logic [ROW_W-1:0] r2m_row;
  logic [ROW_W-1:0] m2r_row;

  // Write port: one bank per cycle, selected by wr_sel.
  // NOTE: the storage arrays have no reset branch on purpose; clearing them
  // would need a per-entry reset mux and software always programs entries
  // before use. Non-blocking assignment keeps the combinational read in the
  // same cycle seeing the old contents (read-before-write).
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (wr_sel == SEL_M2R) begin
        m2r_mem[wr_addr] <= wr_data;
      end else begin
        r2m_mem[wr_addr] <= wr_data;
      end
    end
  end

  // Read port: fetch both banks and regroup stage-major bits to [switch][stage].
  always_comb begin
    // NOTE: every output gets a default before the loops so no path through
    // this block leaves a bit unassigned (no latch).
    rd_r2m  = '0;
    rd_m2r  = '0;
    r2m_row = r2m_mem[rd_addr];
    m2r_row = m2r_mem[rd_addr];
    for (int s = 0; s < STAGE_NUM; s++) begin
      for (int w = 0; w < SWITCH_NUM; w++) begin
        rd_r2m[w][s] = r2m_row[s*SWITCH_NUM + w];
        rd_m2r[w][s] = m2r_row[s*SWITCH_NUM + w];
      end
    end
  end

endmodule

// File: rtl/benes_cfg_sequencer.sv
// Switch-configuration sequencer for the R2M and M2R Benes networks.
// Accepts (config ID, hold length) commands, snapshots the table entry into
// output registers and holds it for cmd_len+1 cycles. A command accepted on
// the final hold cycle takes over on the next cycle with no gap.
module benes_cfg_sequencer #(
  parameter int SWITCH_NUM = benes_cfg_sequencer_pkg::SWITCH_NUM,
  parameter int STAGE_NUM  = benes_cfg_sequencer_pkg::STAGE_NUM,
  parameter int CFG_DEPTH  = benes_cfg_sequencer_pkg::CFG_DEPTH,
  parameter int LEN_W      = benes_cfg_sequencer_pkg::LEN_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  cfg_wr_en,
  input  logic                                  cfg_wr_sel,
  input  logic [$clog2(CFG_DEPTH)-1:0]          cfg_wr_addr,
  input  logic [STAGE_NUM*SWITCH_NUM-1:0]       cfg_wr_data,
  input  logic                                  cmd_valid,
  output logic                                  cmd_ready,
  input  logic [$clog2(CFG_DEPTH)-1:0]          cmd_cfg_id,
  input  logic [LEN_W-1:0]                      cmd_len,
  output logic [SWITCH_NUM-1:0][0:STAGE_NUM-1]  o_module_select,
  output logic [SWITCH_NUM-1:0][0:STAGE_NUM-1]  o_slot_select,
  output logic                                  o_cfg_valid,
  output logic [$clog2(CFG_DEPTH)-1:0]          o_cfg_id,
  output logic                                  o_last
);
  import benes_cfg_sequencer_pkg::*;

  localparam int ID_W = $clog2(CFG_DEPTH);

  typedef logic [SWITCH_NUM-1:0][0:STAGE_NUM-1] sel_t;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  sel_t             mod_sel_q, mod_sel_d;
  sel_t             slot_sel_q, slot_sel_d;
  logic [ID_W-1:0]  cfg_id_q, cfg_id_d;

  sel_t             tbl_r2m;
  sel_t             tbl_m2r;
  logic             cnt_zero;
  logic             cmd_fire;

  // Configuration storage, read on the incoming command's ID.
  benes_cfg_table #(
    .SWITCH_NUM (SWITCH_NUM),
    .STAGE_NUM  (STAGE_NUM),
    .CFG_DEPTH  (CFG_DEPTH)
  ) u_table (
    .clk     (clk),
    .wr_en   (cfg_wr_en),
    .wr_sel  (cfg_wr_sel),
    .wr_addr (cfg_wr_addr),
    .wr_data (cfg_wr_data),
    .rd_addr (cmd_cfg_id),
    .rd_r2m  (tbl_r2m),
    .rd_m2r  (tbl_m2r)
  );

  assign cnt_zero = (cnt_q == '0);
  assign cmd_fire = cmd_valid && cmd_ready;

  // State, hold counter and output snapshot registers; reset dominates any command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      mod_sel_q  <= '0;
      slot_sel_q <= '0;
      cfg_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mod_sel_q  <= mod_sel_d;
      slot_sel_q <= slot_sel_d;
      cfg_id_q   <= cfg_id_d;
    end
  end

  // Next state: enter/stay in HOLD on acceptance, fall back to IDLE when the hold ends unrenewed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_zero && !cmd_fire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: load snapshot on acceptance, otherwise count down while holding.
  always_comb begin
    cnt_d      = cnt_q;
    mod_sel_d  = mod_sel_q;
    slot_sel_d = slot_sel_q;
    cfg_id_d   = cfg_id_q;
    if (cmd_fire) begin
      cnt_d      = cmd_len;
      mod_sel_d  = tbl_r2m;
      slot_sel_d = tbl_m2r;
      cfg_id_d   = cmd_cfg_id;
    end else if ((state_q == ST_HOLD) && !cnt_zero) begin
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  // Outputs: ready depends only on state/counter, selects hold their last value in IDLE.
  always_comb begin
    cmd_ready       = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && cnt_zero);
    o_cfg_valid     = (state_q == ST_HOLD);
    o_last          = (state_q == ST_HOLD) && cnt_zero;
    o_module_select = mod_sel_q;
    o_slot_select   = slot_sel_q;
    o_cfg_id        = cfg_id_q;
  end

endmodule

// File: tb/tb_benes_cfg_sequencer.sv
// Scoreboard bench for benes_cfg_sequencer: stimulus pushes one expected
// record per held cycle on every accepted command; a negedge monitor pops and
// compares whenever o_cfg_valid is high.
module tb_benes_cfg_sequencer;
  import benes_cfg_sequencer_pkg::*;

  localparam int CW = CFG_BITS;

  typedef struct {
    logic [CFG_AW-1:0] id;
    net_cfg_t          mod;
    net_cfg_t          slot;
    logic              last;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_wr_en;
  logic                 cfg_wr_sel;
  logic [CFG_AW-1:0]    cfg_wr_addr;
  logic [CW-1:0]        cfg_wr_data;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [CFG_AW-1:0]    cmd_cfg_id;
  logic [LEN_W-1:0]     cmd_len;
  net_cfg_t             o_module_select;
  net_cfg_t             o_slot_select;
  logic                 o_cfg_valid;
  logic [CFG_AW-1:0]    o_cfg_id;
  logic                 o_last;

  int       n_vec = 0;
  int       n_err = 0;
  bit       mon_en = 1'b0;
  exp_t     exp_q[$];
  exp_t     e;
  net_cfg_t m_r2m [CFG_DEPTH];
  net_cfg_t m_m2r [CFG_DEPTH];

  benes_cfg_sequencer dut (
    .clk             (clk),
    .rst             (rst),
    .cfg_wr_en       (cfg_wr_en),
    .cfg_wr_sel      (cfg_wr_sel),
    .cfg_wr_addr     (cfg_wr_addr),
    .cfg_wr_data     (cfg_wr_data),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_cfg_id      (cmd_cfg_id),
    .cmd_len         (cmd_len),
    .o_module_select (o_module_select),
    .o_slot_select   (o_slot_select),
    .o_cfg_valid     (o_cfg_valid),
    .o_cfg_id        (o_cfg_id),
    .o_last          (o_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Asymmetric per-seed pattern so stage/switch mix-ups show up.
  function automatic net_cfg_t pat(input int seed);
    net_cfg_t v;
    for (int w = 0; w < SWITCH_NUM; w++)
      for (int s = 0; s < STAGE_NUM; s++)
        v[w][s] = (((w * 7) + (s * 3) + seed) % 5) < 2;
    return v;
  endfunction

  function automatic net_cfg_t checker_pat();
    net_cfg_t v;
    for (int w = 0; w < SWITCH_NUM; w++)
      for (int s = 0; s < STAGE_NUM; s++)
        v[w][s] = ((w + s) % 2) == 1;
    return v;
  endfunction

  // Write-port layout: stage s occupies bits [s*SWITCH_NUM +: SWITCH_NUM].
  function automatic logic [CW-1:0] flat(input net_cfg_t v);
    logic [CW-1:0] f;
    for (int s = 0; s < STAGE_NUM; s++)
      for (int w = 0; w < SWITCH_NUM; w++)
        f[s*SWITCH_NUM + w] = v[w][s];
    return f;
  endfunction

  task automatic wr(input logic sel, input logic [CFG_AW-1:0] addr, input net_cfg_t v);
    cfg_wr_en   = 1'b1;
    cfg_wr_sel  = sel;
    cfg_wr_addr = addr;
    cfg_wr_data = flat(v);
    tick();
    cfg_wr_en = 1'b0;
    if (sel) m_m2r[addr] = v;
    else     m_r2m[addr] = v;
  endtask

  // Offer a command until accepted; expected hold cycles are queued at acceptance.
  task automatic issue(input logic [CFG_AW-1:0] id, input logic [LEN_W-1:0] len,
                       output int waits, output logic last_at_hs);
    exp_t x;
    waits      = 0;
    last_at_hs = 1'b0;
    cmd_valid  = 1'b1;
    cmd_cfg_id = id;
    cmd_len    = len;
    while (!cmd_ready && waits < 400) begin
      tick();
      waits++;
    end
    if (!cmd_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL issue_timeout: cmd_ready stayed %b, required 1", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    last_at_hs = o_last;
    for (int i = 0; i <= int'(len); i++) begin
      x.id   = id;
      x.mod  = m_r2m[id];
      x.slot = m_m2r[id];
      x.last = (i == int'(len));
      exp_q.push_back(x);
    end
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (o_cfg_valid && n < 400) begin
      tick();
      n++;
    end
    if (o_cfg_valid) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: o_cfg_valid still 1 after %0d cycles, required 0", name, n);
    end
  endtask

  // Monitor: compare every active output cycle against the queued expectation.
  always @(negedge clk) begin
    if (mon_en) begin
      if (o_cfg_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL mon_unexpected: got valid with id %0d, required no output", o_cfg_id);
        end else begin
          e = exp_q.pop_front();
          check("mon_id",   CW'(o_cfg_id),    CW'(e.id));
          check("mon_r2m",  o_module_select,  e.mod);
          check("mon_m2r",  o_slot_select,    e.slot);
          check("mon_last", CW'(o_last),      CW'(e.last));
        end
      end else begin
        check("mon_idle_last", CW'(o_last), CW'(0));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w;
    int   cnt;
    logic l;

    rst         = 1'b1;
    cfg_wr_en   = 1'b0;
    cfg_wr_sel  = 1'b0;
    cfg_wr_addr = '0;
    cfg_wr_data = '0;
    cmd_valid   = 1'b0;
    cmd_cfg_id  = '0;
    cmd_len     = '0;

    // Reset held for three cycles.
    repeat (3) tick();
    rst = 1'b0;
    check("rst_r2m",   o_module_select, CW'(0));
    check("rst_m2r",   o_slot_select,   CW'(0));
    check("rst_valid", CW'(o_cfg_valid), CW'(0));
    check("rst_id",    CW'(o_cfg_id),    CW'(0));
    check("rst_last",  CW'(o_last),      CW'(0));
    check("rst_ready", CW'(cmd_ready),   CW'(1));
    mon_en = 1'b1;

    // Program the entries used below.
    wr(SEL_R2M, 4'd3, '1);
    wr(SEL_M2R, 4'd3, checker_pat());
    wr(SEL_R2M, 4'd1, pat(1));
    wr(SEL_M2R, 4'd1, pat(2));
    wr(SEL_R2M, 4'd2, pat(3));
    wr(SEL_M2R, 4'd2, pat(4));
    wr(SEL_R2M, 4'd4, pat(5));
    wr(SEL_M2R, 4'd4, pat(6));
    wr(SEL_R2M, 4'd5, pat(7));
    wr(SEL_M2R, 4'd5, pat(8));

    // Single command: id 3, five-cycle hold, then selects held in IDLE.
    check("single_pre_valid", CW'(o_cfg_valid), CW'(0));
    issue(4'd3, 8'd4, w, l);
    check("single_valid_next", CW'(o_cfg_valid), CW'(1));
    check("single_ready_low",  CW'(cmd_ready),   CW'(0));
    repeat (5) tick();
    check("single_idle_valid", CW'(o_cfg_valid), CW'(0));
    check("single_idle_r2m",   o_module_select,  m_r2m[3]);
    check("single_idle_m2r",   o_slot_select,    m_m2r[3]);
    check("single_idle_id",    CW'(o_cfg_id),    CW'(3));
    check("single_idle_ready", CW'(cmd_ready),   CW'(1));

    // Back-to-back: id 1 len 0 then id 2 len 1 with no gap.
    issue(4'd1, 8'd0, w, l);
    check("b2b_first_last",  CW'(o_last),    CW'(1));
    check("b2b_first_ready", CW'(cmd_ready), CW'(1));
    issue(4'd2, 8'd1, w, l);
    check("b2b_hs_on_last", CW'(l),           CW'(1));
    check("b2b_wait",       CW'(w),           CW'(0));
    check("b2b_valid_1",    CW'(o_cfg_valid), CW'(1));
    tick();
    check("b2b_valid_2",    CW'(o_cfg_valid), CW'(1));
    check("b2b_last_ready", CW'(cmd_ready),   CW'(1));
    tick();
    check("b2b_idle", CW'(o_cfg_valid), CW'(0));

    // Write collision on entry 5: same-cycle command sees old data, next sees new.
    cfg_wr_en   = 1'b1;
    cfg_wr_sel  = SEL_R2M;
    cfg_wr_addr = 4'd5;
    cfg_wr_data = flat(pat(9));
    issue(4'd5, 8'd0, w, l);
    cfg_wr_en = 1'b0;
    m_r2m[5]  = pat(9);
    check("coll_wait", CW'(w), CW'(0));
    issue(4'd5, 8'd0, w, l);
    wait_idle("coll_idle");

    // Backpressure: command held during a len=10 hold is taken on the last cycle.
    issue(4'd3, 8'd10, w, l);
    issue(4'd1, 8'd0, w, l);
    check("bp_ready_low_cycles", CW'(w), CW'(10));
    check("bp_hs_on_last",       CW'(l), CW'(1));
    wait_idle("bp_idle");

    // Maximum length: 256 valid cycles; rewriting the active entry must not disturb it.
    issue(4'd4, 8'd255, w, l);
    wr(SEL_R2M, 4'd4, pat(11));
    cnt = 1;
    while (o_cfg_valid && cnt < 400) begin
      cnt++;
      tick();
    end
    check("maxlen_cycles", CW'(cnt), CW'(256));
    issue(4'd4, 8'd0, w, l);
    wait_idle("maxlen_idle");

    // Reset mid-hold with a command offered during reset.
    issue(4'd3, 8'd6, w, l);
    tick();
    rst        = 1'b1;
    cmd_valid  = 1'b1;
    cmd_cfg_id = 4'd1;
    cmd_len    = 8'd3;
    tick();
    rst       = 1'b0;
    cmd_valid = 1'b0;
    exp_q.delete();
    check("mrst_r2m",   o_module_select,  CW'(0));
    check("mrst_m2r",   o_slot_select,    CW'(0));
    check("mrst_valid", CW'(o_cfg_valid), CW'(0));
    check("mrst_id",    CW'(o_cfg_id),    CW'(0));
    check("mrst_last",  CW'(o_last),      CW'(0));
    check("mrst_ready", CW'(cmd_ready),   CW'(1));
    tick();
    check("mrst_cmd_ignored", CW'(o_cfg_valid), CW'(0));
    issue(4'd3, 8'd0, w, l);
    check("mrst_table_kept", o_module_select, m_r2m[3]);
    wait_idle("mrst_idle");

    repeat (2) tick();
    check("queue_drained", CW'(exp_q.size()), CW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
